// File: rtl/drive_state_unit_if.sv
// Drive-state bus between the manual-mode controller and drive_state_unit.
// The master (manual mode) issues power, drive-state and light requests; the
// slave (drive_state_unit) returns the registered power/state/motion status and
// the blinking turn indicators.
interface drive_state_unit_if;
  logic       power_on;
  logic       power_off;
  logic       manual_power;
  logic [1:0] next_state;
  logic [3:0] next_moving_state;
  logic       turn_left_req;
  logic       turn_right_req;
  logic       power;
  logic [1:0] state;
  logic [3:0] moving_state;
  logic       turn_left_led;
  logic       turn_right_led;

  modport master (
    output power_on, power_off, manual_power, next_state, next_moving_state,
           turn_left_req, turn_right_req,
    input  power, state, moving_state, turn_left_led, turn_right_led
  );

  modport slave (
    input  power_on, power_off, manual_power, next_state, next_moving_state,
           turn_left_req, turn_right_req,
    output power, state, moving_state, turn_left_led, turn_right_led
  );
endinterface

// File: rtl/drive_state_unit.sv
// drive_state_unit: power sequencing, drive/motion state registers, turn-LED
// blinker and (optionally) an odometer.
// Optional feature: define MILEAGE_EN to add the 24-bit mileage output and its
// tick counter; without it the port and counters do not exist.
module drive_state_unit #(
  parameter int BLINK_HALF = 50000000,
  parameter int MILE_TICK  = 100000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  drive_state_unit_if.slave    bus
`ifdef MILEAGE_EN
  ,
  output logic [23:0]          mileage
`endif
);

  localparam int BW = $clog2(BLINK_HALF);

  typedef enum logic [1:0] {
    NSTART = 2'b00,
    START  = 2'b01,
    MOVING = 2'b10
  } drive_e;

  typedef enum logic [3:0] {
    NON_MOVING   = 4'b0000,
    MOVE_FORWARD = 4'b0001,
    MOVE_BACK    = 4'b0010,
    TURN_LEFT    = 4'b0100,
    TURN_RIGHT   = 4'b1000
  } move_e;

  // Unused code 11 collapses to NSTART.
  function automatic drive_e decode_state(input logic [1:0] code);
    case (code)
      2'b01:   return START;
      2'b10:   return MOVING;
      default: return NSTART;
    endcase
  endfunction

  // Any code other than the five one-hot/zero motions collapses to NON_MOVING.
  function automatic move_e decode_move(input logic [3:0] code);
    case (code)
      4'b0001: return MOVE_FORWARD;
      4'b0010: return MOVE_BACK;
      4'b0100: return TURN_LEFT;
      4'b1000: return TURN_RIGHT;
      default: return NON_MOVING;
    endcase
  endfunction

  logic          pon1_q, pon1_d;
  logic          pon2_q, pon2_d;
  logic          power_q, power_d;
  drive_e        state_q, state_d;
  move_e         moving_q, moving_d;
  logic [1:0]    req_q, req_d;      // {left, right}
  logic [BW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [1:0]    led_q, led_d;      // {left, right}
  logic          pon_edge;
  logic          load;

  // Next-state logic for power, drive state, light requests and blinker.
  always_comb begin
    pon1_d   = bus.power_on;
    pon2_d   = pon1_q;
    pon_edge = pon1_q & ~pon2_q;

    // Shutdown has priority; turning on needs a fresh registered edge.
    if (power_q) begin
      power_d = ~bus.power_off & bus.manual_power;
    end else begin
      power_d = pon_edge & ~bus.power_off;
    end

    // Status only follows requests while power is on and not falling.
    load    = power_q & power_d;
    state_d = load ? decode_state(bus.next_state) : NSTART;
    if (load && (state_d == MOVING)) begin
      moving_d = decode_move(bus.next_moving_state);
    end else begin
      moving_d = NON_MOVING;
    end
    req_d = load ? {bus.turn_left_req, bus.turn_right_req} : 2'b00;

    // Blinker: idle at zero, restart lit on a new request, else count and wrap.
    if (req_d == 2'b00) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (req_q == 2'b00) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == BW'(BLINK_HALF - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + BW'(1);
      phase_d = phase_q;
    end
    led_d = req_d & {2{phase_d}};
  end

  // Control and status registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pon1_q   <= 1'b0;
      pon2_q   <= 1'b0;
      power_q  <= 1'b0;
      state_q  <= NSTART;
      moving_q <= NON_MOVING;
      req_q    <= 2'b00;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      led_q    <= 2'b00;
    end else begin
      pon1_q   <= pon1_d;
      pon2_q   <= pon2_d;
      power_q  <= power_d;
      state_q  <= state_d;
      moving_q <= moving_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
    end
  end

  assign bus.power          = power_q;
  assign bus.state          = state_q;
  assign bus.moving_state   = moving_q;
  assign bus.turn_left_led  = led_q[1];
  assign bus.turn_right_led = led_q[0];

`ifdef MILEAGE_EN
  localparam int TW = $clog2(MILE_TICK);

  logic [TW-1:0] tick_q, tick_d;
  logic [23:0]   mileage_q, mileage_d;

  // Odometer: tick while actually moving, hold otherwise, saturate at max.
  always_comb begin
    tick_d    = tick_q;
    mileage_d = mileage_q;
    if ((state_q == MOVING) && (moving_q != NON_MOVING)) begin
      if (tick_q == TW'(MILE_TICK - 1)) begin
        tick_d = '0;
        if (mileage_q != 24'hFFFFFF) begin
          mileage_d = mileage_q + 24'd1;
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  // Odometer registers; only reset clears them, power-off keeps them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q    <= '0;
      mileage_q <= '0;
    end else begin
      tick_q    <= tick_d;
      mileage_q <= mileage_d;
    end
  end

  assign mileage = mileage_q;
`endif

endmodule

// File: doc/drive_state_unit.md
DRIVE_STATE_UNIT -- requirements
Module: drive_state_unit

Interface
REQ-001 Parameter BLINK_HALF, default 50000000, SHALL set turn-LED half-period in clk cycles (minimum 2).
REQ-002 Parameter MILE_TICK, default 100000000, SHALL set clk cycles of motion per mileage unit (minimum 2).
REQ-003 clk  in  1  SHALL be the single clock; all flops SHALL be rising-edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 power_on  in  1  SHALL be the power-on button level; only its rising edge is used.
REQ-006 power_off  in  1  SHALL be the power-off button level; active high.
REQ-007 manual_power  in  1  SHALL be the manual-mode power request; 0 means stall shutdown.
REQ-008 next_state  in  2  SHALL be the requested drive state: NSTART=00, START=01, MOVING=10.
REQ-009 next_moving_state  in  4  SHALL be the requested motion: NON_MOVING=0000, MOVE_FORWARD=0001, MOVE_BACK=0010, TURN_LEFT=0100, TURN_RIGHT=1000.
REQ-010 turn_left_req, turn_right_req  in  1  SHALL be the combinational light requests from manual mode.
REQ-011 power  out  1  SHALL be the registered power state, fed back to manual mode.
REQ-012 state  out  2  SHALL be the registered drive state, fed back to manual mode.
REQ-013 moving_state  out  4  SHALL be the registered motion state, fed back to manual mode.
REQ-014 turn_left_led, turn_right_led  out  1  SHALL be the blinking turn indicators.
REQ-015 mileage  out  24  SHALL be the accumulated distance count (present only with MILEAGE_EN).

Function
REQ-016 power SHALL set 0->1 on the cycle after a registered rising edge of power_on.
REQ-017 power SHALL clear 1->0 on the next edge when power_off=1 or manual_power=0.
REQ-018 power_off SHALL win over a simultaneous power_on edge; power stays 0.
REQ-019 power_on held high after a shutdown SHALL NOT re-power; a new rising edge is required.
REQ-020 While power=1, state and moving_state SHALL load next_state and next_moving_state each clk (1-cycle latency).
REQ-021 While power=0, or on the cycle power falls, state SHALL be NSTART and moving_state SHALL be NON_MOVING.
REQ-022 next_state=11 SHALL load as NSTART; any non-listed next_moving_state code SHALL load as NON_MOVING.
REQ-023 moving_state SHALL be forced NON_MOVING whenever the loaded state is not MOVING.
REQ-024 Light requests SHALL be registered (req_q) every clk; req_q SHALL be 0 while power=0.
REQ-025 The blink counter SHALL count 0..BLINK_HALF-1 and wrap, toggling phase at each wrap, while req_q is nonzero.
REQ-026 When req_q goes from 00 to nonzero, the counter SHALL clear and phase SHALL be 1, so the LED lights on the next cycle.
REQ-027 Each LED SHALL equal its req_q bit AND phase; hazard (both bits set) SHALL blink both LEDs in phase.
REQ-028 With req_q=00, both LEDs SHALL be 0, the counter SHALL be 0 and phase SHALL be 0.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear power, req_q, phase, all counters and mileage, set state=NSTART and moving_state=NON_MOVING, and drive both LEDs to 0.
REQ-030 Reset mid-motion or mid-blink SHALL take effect immediately; operation resumes on the first clk edge after release, with power=0.

Configuration
REQ-031 With MILEAGE_EN defined, a tick counter SHALL advance each clk while state=MOVING and moving_state!=NON_MOVING.
REQ-032 With MILEAGE_EN, the tick counter SHALL hold (not clear) when motion stops, and mileage SHALL retain its value across power-off.
REQ-033 With MILEAGE_EN, when the tick counter reaches MILE_TICK-1 it SHALL wrap to 0 and mileage SHALL increment, saturating at 24'hFFFFFF.
REQ-034 Without MILEAGE_EN, the mileage port and its counters SHALL NOT exist; all other behaviour SHALL be unchanged.

Verification
REQ-035 Power edge: rst_n release, pulse power_on -> power=1 on the 2nd edge; hold power_on with manual_power=0 -> power=0 and stays 0.
REQ-036 Load: power=1, next_state=10, next_moving_state=0100 -> state=10, moving_state=0100 one edge later; next_moving_state=0011 -> moving_state=0000.
REQ-037 Blink: BLINK_HALF=4, turn_right_req=1 -> turn_right_led pattern 1111 0000 1111, turn_left_led stays 0; both requests -> both LEDs in phase.
REQ-038 Conflict: power_off=1 in the same cycle as a power_on edge -> power stays 0, state=00.
REQ-039 Mileage (MILEAGE_EN): MILE_TICK=3, 7 moving cycles -> mileage=2; preload 24'hFFFFFF -> stays FFFFFF.
REQ-040 Async reset: assert rst_n=0 between clk edges while moving and blinking -> all outputs cleared before the next edge.
